// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the NOP word and the PC step, plus a word-alignment helper.
package fetch_pkg;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: reset load, redirect load and +4 increment.
// Priority is reset, then load, then increment; all decisions come from instr_fetch.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [31:0] load_pc,
    input  logic        inc_en,
    output logic [31:0] pc
);

    // PC update; the low two bits are forced to zero on every load
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= word_align(RESET_PC);
        end else if (load_en) begin
            pc <= word_align(load_pc);
        end else if (inc_en) begin
            pc <= pc + PC_STEP;
        end else begin
            pc <= pc;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding word request at a time, captures the
// returned word for IF/ID, holds it across stalls and squashes fetches on redirect.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        valid
);

    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic [31:0] pc_s;
    logic        pc_load_s;
    logic        pc_inc_s;
    logic        capture_s;
    logic        release_s;
    logic [31:0] instr_r;
    logic [31:0] npc_r;
    logic        valid_r;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk     (clk),
        .reset   (reset),
        .load_en (pc_load_s),
        .load_pc (redirect_pc),
        .inc_en  (pc_inc_s),
        .pc      (pc_s)
    );

    // Next-state and control decode
    always_comb begin
        next_state_s = state_r;
        pc_load_s    = 1'b0;
        pc_inc_s     = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (redirect) begin
                    pc_load_s = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_load_s    = 1'b1;
                    next_state_s = ST_DRAIN;
                end else if (imem_ack) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_load_s    = 1'b1;
                    release_s    = 1'b1;
                    next_state_s = ST_FETCH;
                end else if (!stall) begin
                    pc_inc_s     = 1'b1;
                    release_s    = 1'b1;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                // A redirect here only retargets; the squashed ack still ends the drain
                pc_load_s = redirect;
                if (imem_ack) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // IF/ID output registers; instr returns to NOP whenever valid drops
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            npc_r   <= 32'h0000_0000;
        end else if (capture_s) begin
            valid_r <= 1'b1;
            instr_r <= imem_rdata;
            npc_r   <= pc_s + PC_STEP;
        end else if (release_s) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            npc_r   <= npc_r;
        end else begin
            valid_r <= valid_r;
            instr_r <= instr_r;
            npc_r   <= npc_r;
        end
    end

    assign imem_req  = (state_r == ST_FETCH) && !redirect;
    assign imem_addr = pc_s;
    assign instr     = instr_r;
    assign npc       = npc_r;
    assign valid     = valid_r;

endmodule
